// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed 4-digit, common-anode, active-low
// seven-segment driver for a mod-11 counter. Digits 1-0 show the count,
// digits 3-2 show a BCD tally of 10->0 wraps.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (blanks leading zeros
// on digits 1 and 3 when defined).
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  localparam logic [19:0] PRESC_TC = 20'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  // Segment pattern {g,f,e,d,c,b,a}, active low, for a decimal digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Two-digit BCD increment with 99 -> 00 rollover.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4] = 4'd0;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  logic [3:0]  count_q, count_d;
  logic [7:0]  wraps_q, wraps_d;
  logic [19:0] presc_q, presc_d;
  state_t      state_q, state_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic        wrap_s;
  logic        legal_s;
  logic [3:0]  cnt_ones_s;
  logic [3:0]  cnt_tens_s;

  // Capture, wrap tally, prescaler and scan sequencing.
  always_comb begin
    count_d = count;
    wrap_s  = (count_q == 4'd10) && (count == 4'd0);
    if (wrap_s) begin
      wraps_d = bcd_inc(wraps_q);
    end else begin
      wraps_d = wraps_q;
    end
    if (presc_q == PRESC_TC) begin
      presc_d = 20'd0;
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        DIG3:    state_d = DIG0;
        default: state_d = DIG0;
      endcase
    end else begin
      presc_d = presc_q + 20'd1;
      state_d = state_q;
    end
  end

  // Next digit content from the current scan state, count_q and wraps.
  always_comb begin
    legal_s    = (count_q <= 4'd10);
    cnt_ones_s = (count_q == 4'd10) ? 4'd0 : count_q;
    cnt_tens_s = (count_q == 4'd10) ? 4'd1 : 4'd0;
    case (state_q)
      DIG0: begin
        an_d  = 4'b1110;
        seg_d = legal_s ? seg_of(cnt_ones_s) : SEG_DASH;
      end
      DIG1: begin
        an_d = 4'b1101;
        if (!legal_s) begin
          seg_d = SEG_DASH;
        end else begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
          seg_d = (cnt_tens_s == 4'd0) ? SEG_BLANK : seg_of(cnt_tens_s);
`else
          seg_d = seg_of(cnt_tens_s);
`endif
        end
      end
      DIG2: begin
        an_d  = 4'b1011;
        seg_d = seg_of(wraps_q[3:0]);
      end
      DIG3: begin
        an_d = 4'b0111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        seg_d = (wraps_q[7:4] == 4'd0) ? SEG_BLANK : seg_of(wraps_q[7:4]);
`else
        seg_d = seg_of(wraps_q[7:4]);
`endif
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
      wraps_q <= 8'h00;
      presc_q <= 20'd0;
      state_q <= DIG0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'b1111;
    end else begin
      count_q <= count_d;
      wraps_q <= wraps_d;
      presc_q <= presc_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule
